spi_peripheral: RTL and testbench
=================================

Name: spi_peripheral

Overview:
SPI mode-0 target that sits directly upstream of pwm_peripheral. It receives 16-bit frames from an external controller and writes the five 8-bit control registers the PWM stage consumes: output enables, PWM enables and duty cycle. Its outputs wire straight into pwm_peripheral's register inputs at the top level. It is clocked by the system clock; sclk, copi and ncs are asynchronous inputs and are oversampled.

Parameters:
SYNC_STAGES, 2, flop depth of each input synchronizer (minimum 2).
MAX_ADDR, 7'h04, highest writable register address; any frame addressed above it is discarded.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  reset, synchronous, active-low.
sclk  input  1  SPI serial clock, asynchronous.
copi  input  1  SPI controller-out data, asynchronous.
ncs  input  1  SPI chip select, active-low, asynchronous.
cipo  output  1  SPI target-out data; 0 unless SPI_READBACK_EN.
cipo_oe  output  1  cipo output enable; 0 unless SPI_READBACK_EN.
en_reg_out_7_0  output  8  register 0x00.
en_reg_out_15_8  output  8  register 0x01.
en_reg_pwm_7_0  output  8  register 0x02.
en_reg_pwm_15_8  output  8  register 0x03.
pwm_duty_cycle  output  8  register 0x04.
txn_done  output  1  one-cycle pulse on each committed write.

Behaviour:
- Reset: on a clk edge with rst_n=0, all five registers go to 8'h00. Shift register, bit counter and synchronizers clear. txn_done=0, cipo=0, cipo_oe=0. State goes to IDLE.
- Synchronizers: sclk, copi and ncs each pass through SYNC_STAGES flops. Edges are detected on the synchronized values. sclk_rise, ncs_fall and ncs_rise are each 1-cycle pulses.
- Clock ratio: the clk period must be at most 1/8 of the sclk period. The nominal case is clk 10 MHz with sclk up to 1 MHz.
- Frame format, MSB first: bit15 is R/W (1=write), bits14:8 are the address, bits7:0 are the data.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE -> SHIFT on ncs_fall. On entry, the bit counter clears to 0.
  - SHIFT: on each sclk_rise, copi_sync shifts into bit0 of a 16-bit shift register. The 5-bit counter increments and saturates at 17.
  - SHIFT -> COMMIT on ncs_rise.
  - COMMIT lasts 1 cycle, then returns to IDLE.
- Commit rule: the write is performed in COMMIT only if all of the following hold: counter==16, bit15==1, address<=MAX_ADDR. The addressed register updates at the end of the COMMIT cycle. txn_done is high during that same cycle.
- Discarded frames leave all registers unchanged with no txn_done:
  - counter<16 (short frame);
  - counter>16 (long frame);
  - bit15==0 (read);
  - address>MAX_ADDR.
- An sclk_rise while in IDLE (ncs high) is ignored.
- If ncs_fall and ncs_rise occur closer together than the synchronizer allows, a zero-bit frame results and is discarded.
- Reset mid-frame: the frame is aborted. If rst_n is released while ncs is low, that frame is ignored, because only a fresh ncs_fall leaves IDLE.
- Registers hold their value indefinitely between writes. Writes to different addresses never disturb each other.

Optional Feature:
SPI_READBACK_EN
- Defined: in a frame with bit15==0, when the counter reaches 8, the tx shift register loads the addressed register value. Out-of-range addresses load 8'h00.
  - cipo_oe=1 from that point until ncs_rise.
  - cipo presents data MSB first and changes on each synchronized sclk falling edge, so the controller samples it on the following rising edge.
  - cipo returns to 0 and cipo_oe to 0 on ncs_rise or reset.
- Undefined: cipo and cipo_oe are tied to 0. No tx logic is synthesized.

Decomposition:
- Package spi_periph_pkg holds:
  - FRAME_BITS=16;
  - address constants ADDR_EN_OUT_7_0=7'h00, ADDR_EN_OUT_15_8=7'h01, ADDR_EN_PWM_7_0=7'h02, ADDR_EN_PWM_15_8=7'h03, ADDR_PWM_DUTY=7'h04;
  - the state enum typedef spi_state_t {IDLE, SHIFT, COMMIT}.
- One sub-module, spi_edge_sync: a parameterized SYNC_STAGES synchronizer plus rise/fall pulse generation. It is instantiated once each for sclk, copi and ncs; copi uses only the level output.

Test Plan:
1. Write frame 16'h80F0 (addr 0x00, data 0xF0) -> en_reg_out_7_0=0xF0 one cycle after COMMIT, txn_done one pulse, all other registers remain 0x00.
2. Write 16'h8480 then 16'h8301 -> pwm_duty_cycle=0x80, en_reg_pwm_15_8=0x01, and registers 0x00–0x02 are unchanged.
3. Discard cases, each with registers preloaded:
   - write to addr 0x05 data 0xAA;
   - a 12-bit frame;
   - a 17-bit frame;
   - read frame 16'h0000.
   -> no register changes and no txn_done in any case.
4. Assert rst_n=0 for 1 clk after 9 bits of a write to 0x02 -> all registers are 0x00. The rest of that frame is ignored. The next full frame 16'h82FF sets en_reg_pwm_7_0=0xFF.
5. Back-to-back write frames with a 2-sclk-period ncs-high gap, to addrs 0x00–0x04 with data 0x11–0x55 -> each register holds its value, with 5 txn_done pulses.
6. With SPI_READBACK_EN defined, after writing 0x04=0x5A, send read frame 16'h0400 -> cipo shifts 0x5A MSB first on bits 8–15 while cipo_oe=1, and cipo_oe=0 after ncs rises.

Source files
------------

// File: rtl/spi_periph_pkg.sv
// Shared constants and types for the SPI register-write target.
// Frame layout: {rw, addr[6:0], data[7:0]}, MSB first.
package spi_periph_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } spi_state_t;

endpackage

// File: rtl/spi_peripheral_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin with
// single-cycle rise/fall pulses derived from the synchronized level.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 target writing the five PWM control registers.
// Optional cipo readback of the addressed register: SPI_READBACK_EN.
module spi_peripheral
  import spi_periph_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic       cipo_oe,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       txn_done
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic copi_s, copi_rise_unused, copi_fall_unused;
  logic ncs_s, ncs_rise, ncs_fall;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sclk),
    .level(sclk_s),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_copi (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (copi),
    .level(copi_s),
    .rise (copi_rise_unused),
    .fall (copi_fall_unused)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ncs (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (ncs),
    .level(ncs_s),
    .rise (ncs_rise),
    .fall (ncs_fall)
  );

  logic unused_levels;
  assign unused_levels = sclk_s ^ ncs_s;

  spi_state_t  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shreg_q, shreg_d;
  logic [7:0]  regs_q [0:4];
  logic [7:0]  regs_d [0:4];

  logic [6:0] addr;
  logic [7:0] data;
  logic       commit_ok;

  assign addr = shreg_q[14:8];
  assign data = shreg_q[7:0];
  assign commit_ok = (cnt_q == 5'(FRAME_BITS))
                   && shreg_q[15]
                   && (addr <= MAX_ADDR);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    regs_d   = regs_q;
    txn_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shreg_d = {shreg_q[14:0], copi_s};
          // Saturate at 17 so any overlong frame stays distinguishable
          if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
        end
        if (ncs_rise) state_d = COMMIT;
      end
      COMMIT: begin
        state_d = IDLE;
        if (commit_ok) begin
          txn_done = 1'b1;
          unique case (addr)
            ADDR_EN_OUT_7_0:  regs_d[0] = data;
            ADDR_EN_OUT_15_8: regs_d[1] = data;
            ADDR_EN_PWM_7_0:  regs_d[2] = data;
            ADDR_EN_PWM_15_8: regs_d[3] = data;
            ADDR_PWM_DUTY:    regs_d[4] = data;
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      regs_q  <= '{default: 8'h00};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      regs_q  <= regs_d;
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];

`ifdef SPI_READBACK_EN
  logic [7:0] tx_q, tx_d;
  logic       oe_q, oe_d;
  logic [7:0] rd_val;

  always_comb begin
    rd_val = 8'h00;
    if (shreg_d[6:0] <= MAX_ADDR) begin
      unique case (shreg_d[6:0])
        ADDR_EN_OUT_7_0:  rd_val = regs_q[0];
        ADDR_EN_OUT_15_8: rd_val = regs_q[1];
        ADDR_EN_PWM_7_0:  rd_val = regs_q[2];
        ADDR_EN_PWM_15_8: rd_val = regs_q[3];
        ADDR_PWM_DUTY:    rd_val = regs_q[4];
        default:          rd_val = 8'h00;
      endcase
    end
  end

  always_comb begin
    tx_d = tx_q;
    oe_d = oe_q;
    if (sclk_rise && cnt_q == 5'd7 && !shreg_d[7]) begin
      tx_d = rd_val;
      oe_d = 1'b1;
    end else if (sclk_fall && oe_q && cnt_q > 5'd8) begin
      // First fall after the load is skipped so the MSB meets rise 9
      tx_d = {tx_q[6:0], 1'b0};
    end
    if (state_q != SHIFT || ncs_rise) begin
      tx_d = '0;
      oe_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q <= '0;
      oe_q <= 1'b0;
    end else begin
      tx_q <= tx_d;
      oe_q <= oe_d;
    end
  end

  assign cipo    = tx_q[7];
  assign cipo_oe = oe_q;
`else
  logic unused_sclk_fall;
  assign unused_sclk_fall = sclk_fall;
  assign cipo    = 1'b0;
  assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed plus randomized frames against a register-map model
// of the SPI target; readback steps only with SPI_READBACK_EN.
module tb_spi_peripheral;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic       cipo, cipo_oe, txn_done;
  logic [7:0] r0, r1, r2, r3, r4;

  int vectors = 0;
  int miscompares = 0;
  int txn_cnt = 0;
  logic [7:0] mdl [0:4];

  spi_peripheral dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sclk           (sclk),
    .copi           (copi),
    .ncs            (ncs),
    .cipo           (cipo),
    .cipo_oe        (cipo_oe),
    .en_reg_out_7_0 (r0),
    .en_reg_out_15_8(r1),
    .en_reg_pwm_7_0 (r2),
    .en_reg_pwm_15_8(r3),
    .pwm_duty_cycle (r4),
    .txn_done       (txn_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (txn_done === 1'b1) txn_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register-map model: only an exact 16-bit write in range lands.
  function automatic int model(input logic [31:0] v, input int n);
    if (n == 16 && v[15] && v[14:8] <= 7'd4) begin
      mdl[v[10:8]] = v[7:0];
      return 1;
    end
    return 0;
  endfunction

  task automatic drive(input logic [31:0] v, input int n, input int rst_at);
    ncs = 1'b0;
    #100;
    for (int i = n - 1; i >= 0; i--) begin
      copi = v[i];
      #50 sclk = 1'b1;
      #50 sclk = 1'b0;
      if (n - i == rst_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    #50 ncs = 1'b1;
    copi = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_r0"}, 32'(r0), 32'(mdl[0]));
    chk({tag, "_r1"}, 32'(r1), 32'(mdl[1]));
    chk({tag, "_r2"}, 32'(r2), 32'(mdl[2]));
    chk({tag, "_r3"}, 32'(r3), 32'(mdl[3]));
    chk({tag, "_r4"}, 32'(r4), 32'(mdl[4]));
  endtask

  task automatic frame(input string tag, input logic [31:0] v, input int n);
    int t0, exp;
    t0  = txn_cnt;
    exp = model(v, n);
    drive(v, n, 0);
    #200;
    check_regs(tag);
    chk({tag, "_txn"}, 32'(txn_cnt - t0), 32'(exp));
`ifndef SPI_READBACK_EN
    chk({tag, "_cipo"}, {30'd0, cipo, cipo_oe}, 32'd0);
`endif
  endtask

  initial begin
    int t0;
    int found;
    logic [31:0] v;
    logic [7:0]  rb;
    for (int i = 0; i < 5; i++) mdl[i] = 8'h00;

    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_regs("reset");
    chk("reset_txn", 32'(txn_done), 32'd0);
    chk("reset_cipo", 32'(cipo), 32'd0);
    chk("reset_oe", 32'(cipo_oe), 32'd0);

    // Write 0x00 = 0xF0 and check commit timing
    t0 = txn_cnt;
    void'(model(32'h80F0, 16));
    drive(32'h80F0, 16, 0);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      if (txn_done === 1'b1) found = 1;
    end
    chk("t1_txn_seen", 32'(found), 32'd1);
    chk("t1_before", 32'(r0), 32'h00);
    @(negedge clk);
    chk("t1_after", 32'(r0), 32'hF0);
    chk("t1_pulse_end", 32'(txn_done), 32'd0);
    #200;
    check_regs("t1");
    chk("t1_txn", 32'(txn_cnt - t0), 32'd1);

    frame("t2a", 32'h8480, 16);
    frame("t2b", 32'h8301, 16);

    // Back-to-back writes to every register
    t0 = txn_cnt;
    for (int a = 0; a < 5; a++) begin
      v = {16'h0, 1'b1, 7'(a), 8'(8'h11 * (a + 1))};
      void'(model(v, 16));
      drive(v, 16, 0);
      #200;
    end
    check_regs("t5");
    chk("t5_txn", 32'(txn_cnt - t0), 32'd5);

    frame("t3_addr5", 32'h85AA, 16);
    frame("t3_short", 32'h0A5C, 12);
    frame("t3_long", 32'h180AB, 17);
    frame("t3_read", 32'h0000, 16);

    // Reset mid-frame, then a fresh frame
    t0 = txn_cnt;
    drive(32'h8233, 16, 9);
    for (int i = 0; i < 5; i++) mdl[i] = 8'h00;
    #200;
    check_regs("t4_rst");
    chk("t4_txn", 32'(txn_cnt - t0), 32'd0);
    frame("t4_next", 32'h82FF, 16);

`ifdef SPI_READBACK_EN
    frame("t6_wr", 32'h845A, 16);
    rb = 8'h5A;
    v  = 32'h0400;
    ncs = 1'b0;
    #100;
    for (int i = 15; i >= 0; i--) begin
      copi = v[i];
      if (i <= 7) begin
        chk("t6_cipo", 32'(cipo), 32'(rb[i]));
        chk("t6_oe", 32'(cipo_oe), 32'd1);
      end else if (i == 12) begin
        chk("t6_oe_early", 32'(cipo_oe), 32'd0);
      end
      #50 sclk = 1'b1;
      #50 sclk = 1'b0;
    end
    #50 ncs = 1'b1;
    #200;
    chk("t6_oe_off", 32'(cipo_oe), 32'd0);
    chk("t6_cipo_off", 32'(cipo), 32'd0);
    check_regs("t6");
`endif

    // Randomized frames: mixed lengths, directions and addresses
    for (int k = 0; k < 24; k++) begin
      int pick, n;
      pick = $urandom_range(0, 5);
      n = (pick == 0) ? 12 : (pick == 1) ? 17 : 16;
      if (n == 16)
        v = {16'h0, 1'($urandom_range(0, 3) != 0),
             7'($urandom_range(0, 7)), 8'($urandom)};
      else
        v = $urandom;
      frame("rand", v, n);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
